// File: rtl/link_cable_peer.sv
// rtl/link_cable_peer.sv - Game Boy link-cable slave peer (external-clock serial byte exchanger)
// Optional feature: define LINK_CABLE_PEER_TIMEOUT_EN to abort partial bytes after TIMEOUT_CYCLES idle cycles.
module link_cable_peer #(
  parameter int         SYNC_STAGES    = 2,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter logic [7:0] IDLE_BYTE      = 8'hFF
) (
  input  logic       cpu_clock,
  input  logic       reset_n,
  input  logic       sck_in,
  input  logic       sout_in,
  output logic       sin_out,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       err_timeout
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] sout_sync;
  logic                   sck_prev;
  logic                   sck_fall;
  logic                   sck_rise;
  logic                   sout_s;
  logic [7:0]             shifter;
  logic [7:0]             hold_data;
  logic                   hold_full;
  logic [3:0]             bit_cnt;
  logic                   load;
  logic                   start;
  logic [7:0]             start_byte;

  assign sck_fall   = sck_prev & ~sck_sync[SYNC_STAGES-1];
  assign sck_rise   = ~sck_prev & sck_sync[SYNC_STAGES-1];
  assign sout_s     = sout_sync[SYNC_STAGES-1];
  assign tx_ready   = ~hold_full;
  assign load       = tx_valid & ~hold_full;
  assign start      = (state == IDLE) & sck_fall;
  // Byte start uses the pre-cycle holding content, so a coincident load waits for the next transfer.
  assign start_byte = hold_full ? hold_data : IDLE_BYTE;
  assign busy       = (state != IDLE);

  // Bring the master's clock and data into the cpu_clock domain and keep a delayed sck copy for edge detection.
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync  <= '1;
      sout_sync <= '1;
      sck_prev  <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_in};
      sout_sync <= {sout_sync[SYNC_STAGES-2:0], sout_in};
      sck_prev  <= sck_sync[SYNC_STAGES-1];
    end
  end

  // Single-entry holding register for the next response byte.
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_full <= 1'b0;
      hold_data <= 8'h00;
    end else if (load) begin
      hold_full <= 1'b1;
      hold_data <= tx_data;
    end else if (start) begin
      hold_full <= 1'b0;
    end
  end

`ifdef LINK_CABLE_PEER_TIMEOUT_EN
  logic [15:0] idle_cnt;
`else
  assign err_timeout = 1'b0;
`endif

  // Transfer FSM: start on a falling edge, sample on rising edges, drive on falling edges, publish after 8 bits.
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      shifter  <= 8'h00;
      bit_cnt  <= 4'd0;
      sin_out  <= 1'b1;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
`ifdef LINK_CABLE_PEER_TIMEOUT_EN
      idle_cnt    <= 16'd0;
      err_timeout <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef LINK_CABLE_PEER_TIMEOUT_EN
      err_timeout <= 1'b0;
      idle_cnt    <= 16'd0;
`endif
      case (state)
        IDLE: begin
          if (sck_fall) begin
            shifter <= start_byte;
            sin_out <= start_byte[7];
            bit_cnt <= 4'd0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (sck_rise) begin
            shifter <= {shifter[6:0], sout_s};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) state <= DONE;
          end else if (sck_fall && bit_cnt != 4'd0) begin
            sin_out <= shifter[7];
          end
`ifdef LINK_CABLE_PEER_TIMEOUT_EN
          // A stalled master leaves a partial byte; abandon it once the line has been quiet long enough.
          if (!sck_rise && !sck_fall) begin
            if (idle_cnt + 16'd1 == 16'(TIMEOUT_CYCLES)) begin
              state       <= IDLE;
              sin_out     <= 1'b1;
              bit_cnt     <= 4'd0;
              err_timeout <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 16'd1;
            end
          end
`endif
        end
        DONE: begin
          rx_data  <= shifter;
          rx_valid <= 1'b1;
          bit_cnt  <= 4'd0;
          state    <= IDLE;
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_link_cable_peer.sv
// tb/tb_link_cable_peer.sv - self-checking bench for link_cable_peer with a byte-level reference model
module tb_link_cable_peer;

  localparam int HALF = 8;
  localparam int SYNC = 2;

  logic       cpu_clock = 1'b0;
  logic       reset_n   = 1'b0;
  logic       sck_in    = 1'b1;
  logic       sout_in   = 1'b1;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_valid  = 1'b0;
  logic       sin_out;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       err_timeout;

  int compared   = 0;
  int mismatched = 0;
  int rxv_count  = 0;
  int err_count  = 0;

  bit         m_full = 1'b0;
  logic [7:0] m_data = 8'h00;

  always #5 cpu_clock = ~cpu_clock;

  link_cable_peer dut (
    .cpu_clock   (cpu_clock),
    .reset_n     (reset_n),
    .sck_in      (sck_in),
    .sout_in     (sout_in),
    .sin_out     (sin_out),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always @(negedge cpu_clock) begin
    if (rx_valid) rxv_count++;
    if (err_timeout) err_count++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge cpu_clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sin_out"}, sin_out, 1'b1);
    check({tag, "_rx_data"}, rx_data, 8'h00);
    check({tag, "_rx_valid"}, rx_valid, 1'b0);
    check({tag, "_tx_ready"}, tx_ready, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_err_timeout"}, err_timeout, 1'b0);
  endtask

  task automatic offer(input logic [7:0] b);
    tick(1);
    tx_data  = b;
    tx_valid = 1'b1;
    check("offer_tx_ready", tx_ready, !m_full);
    if (!m_full) begin
      m_full = 1'b1;
      m_data = b;
    end
    tick(1);
    tx_valid = 1'b0;
  endtask

  // Master side: nbits clock periods, data MSB first; the last rise of a full byte returns immediately.
  task automatic xfer(input logic [7:0] m, input int nbits, input bit co, input logic [7:0] cdata,
                      output logic [7:0] sent, output logic [7:0] got);
    got  = 8'h00;
    sent = 8'hFF;
    for (int i = 0; i < nbits; i++) begin
      tick(1);
      sck_in  = 1'b0;
      sout_in = m[7-i];
      if (i == 0) begin
        sent   = m_full ? m_data : 8'hFF;
        m_full = 1'b0;
        if (co) begin
          tick(SYNC);
          tx_data  = cdata;
          tx_valid = 1'b1;
          tick(1);
          tx_valid = 1'b0;
          m_full   = 1'b1;
          m_data   = cdata;
          tick(HALF - SYNC - 1);
        end else begin
          tick(HALF);
        end
        check("start_tx_ready", tx_ready, !m_full);
        check("start_busy", busy, 1'b1);
      end else begin
        tick(HALF);
      end
      got[7-i] = sin_out;
      sck_in   = 1'b1;
      if (i != 7) tick(HALF);
    end
  endtask

  task automatic finish_byte(input string tag, input logic [7:0] m, input logic [7:0] sent, input logic [7:0] got);
    int n = 0;
    check({tag, "_sin_bits"}, got, sent);
    while (!rx_valid && n < 30) begin
      tick(1);
      n++;
    end
    check({tag, "_rx_valid_seen"}, rx_valid, 1'b1);
    check({tag, "_rx_data"}, rx_data, m);
    tick(1);
    check({tag, "_rx_valid_single"}, rx_valid, 1'b0);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_sin_hold"}, sin_out, sent[0]);
    tick(HALF);
  endtask

  task automatic full_byte(input string tag, input logic [7:0] m, input bit co, input logic [7:0] cdata);
    logic [7:0] sent;
    logic [7:0] got;
    xfer(m, 8, co, cdata, sent, got);
    finish_byte(tag, m, sent, got);
  endtask

  initial begin
    logic [7:0] sent;
    logic [7:0] got;
    logic [7:0] m;
    int rx_before;
    int err_before;
    int n;

    tick(3);
    check_reset_values("reset");
    reset_n = 1'b1;
    tick(4);

    offer(8'hA5);
    xfer(8'h3C, 8, 1'b0, 8'h00, sent, got);
    check("a5_bits_exact", got, 8'hA5);
    finish_byte("a5_3c", 8'h3C, sent, got);

    xfer(8'h00, 8, 1'b0, 8'h00, sent, got);
    check("idle_bits_exact", got, 8'hFF);
    finish_byte("idle_00", 8'h00, sent, got);

    rx_before = rxv_count;
    offer(8'h01);
    offer(8'h02);
    check("reject_kept_full", tx_ready, 1'b0);
    full_byte("busy_first", 8'h96, 1'b0, 8'h00);
    offer(8'h02);
    full_byte("busy_second", 8'h69, 1'b0, 8'h00);
    check("two_rx_pulses", rxv_count - rx_before, 2);

    full_byte("coincide", 8'h18, 1'b1, 8'h77);
    full_byte("coincide_next", 8'hE7, 1'b0, 8'h00);

    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(1, 0) == 1) offer(8'($urandom));
      m = 8'($urandom);
      full_byte($sformatf("rand%0d", k), m, 1'b0, 8'h00);
    end

    offer(8'h4B);
    xfer(8'hF0, 4, 1'b0, 8'h00, sent, got);
    check("partial_busy", busy, 1'b1);
    offer(8'hD2);
    reset_n = 1'b0;
    tick(2);
    check_reset_values("midreset");
    sck_in  = 1'b1;
    sout_in = 1'b1;
    m_full  = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(HALF);
    full_byte("after_reset_c3", 8'hC3, 1'b0, 8'h00);

`ifdef LINK_CABLE_PEER_TIMEOUT_EN
    rx_before  = rxv_count;
    err_before = err_count;
    xfer(8'hAA, 3, 1'b0, 8'h00, sent, got);
    n = 0;
    while (!err_timeout && n < 5000) begin
      tick(1);
      n++;
    end
    check("timeout_pulse", err_timeout, 1'b1);
    tick(1);
    check("timeout_single", err_timeout, 1'b0);
    check("timeout_busy", busy, 1'b0);
    check("timeout_sin_out", sin_out, 1'b1);
    check("timeout_no_rx", rxv_count - rx_before, 0);
    check("timeout_count", err_count - err_before, 1);
    full_byte("after_timeout_5a", 8'h5A, 1'b0, 8'h00);
`else
    err_before = 0;
    n = 0;
    check("no_timeout_pulses", err_count, err_before + n);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog time limit reached observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
